// File: rtl/nanorv32_ahb_testctrl_if.sv
// AHB-Lite bus bundle between the nanorv32 initiator and the test controller.
interface nanorv32_ahb_testctrl_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hready_out;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hready_out, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hready_out, hresp
    );
endinterface

// File: rtl/nanorv32_ahb_testctrl.sv
// AHB-Lite test controller: RESULT, CYCLE_CNT, SCRATCH and CHAR_OUT registers
// with optional wait states and a two-cycle ERROR response.
module nanorv32_ahb_testctrl #(
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] PASS_CODE   = 32'hCAFFE000,
    parameter logic [31:0] FAIL_CODE   = 32'hDEAD0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nanorv32_ahb_testctrl_if.slave        bus,
    output logic                          test_done,
    output logic                          test_pass,
    output logic                          char_valid,
    output logic [7:0]                    char_data
);
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t      state;
    logic [1:0]  wcnt;
    logic        pend;
    logic [1:0]  a_off;
    logic        a_wr;
    logic        rdy_q;
    logic        resp_q;
    logic [31:0] result;
    logic [31:0] scratch;
    logic [31:0] cnt;
    logic [31:0] rdata;

    logic accept;
    logic legal;
    logic comp;

    assign accept = bus.hsel & bus.htrans[1] & bus.hready;
    assign legal  = (bus.hsize == 3'b010) & (bus.haddr[1:0] == 2'b00)
                  & ~bus.haddr[4];
    // A legal data phase completes once the FSM is back in IDLE.
    assign comp   = pend & (state == IDLE);

    wire unused_ok = ^{bus.haddr[31:5], bus.htrans[0], FAIL_CODE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wcnt   <= 2'd0;
            pend   <= 1'b0;
            a_off  <= 2'd0;
            a_wr   <= 1'b0;
            rdy_q  <= 1'b1;
            resp_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ERR2: begin
                    state  <= IDLE;
                    pend   <= 1'b0;
                    rdy_q  <= 1'b1;
                    resp_q <= 1'b0;
                    if (accept) begin
                        a_off <= bus.haddr[3:2];
                        a_wr  <= bus.hwrite;
                        if (!legal) begin
                            state  <= ERR1;
                            rdy_q  <= 1'b0;
                            resp_q <= 1'b1;
                        end else begin
                            pend <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state <= WAIT;
                                wcnt  <= 2'(WAIT_STATES - 1);
                                rdy_q <= 1'b0;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == 2'd0) begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                ERR1: begin
                    state <= ERR2;
                    rdy_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 32'd0;
            result     <= 32'd0;
            scratch    <= 32'd0;
            test_done  <= 1'b0;
            test_pass  <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= 8'd0;
        end else begin
            cnt        <= cnt + 32'd1;
            char_valid <= 1'b0;
            if (comp && a_wr) begin
                unique case (a_off)
                    2'd0: begin
                        if (!test_done) begin
                            result    <= bus.hwdata;
                            test_done <= 1'b1;
                            test_pass <= (bus.hwdata == PASS_CODE);
                        end
                    end
                    2'd2: scratch <= bus.hwdata;
                    2'd3: begin
                        char_valid <= 1'b1;
                        char_data  <= bus.hwdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (comp && !a_wr) begin
            unique case (a_off)
                2'd0:    rdata = result;
                2'd1:    rdata = cnt;
                2'd2:    rdata = scratch;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign bus.hrdata     = rdata;
    assign bus.hready_out = rdy_q;
    assign bus.hresp      = resp_q;
endmodule

// File: tb/tb_nanorv32_ahb_testctrl.sv
// Directed bench for nanorv32_ahb_testctrl: one instance with no wait
// states and one with two, sharing stimulus and selected by sel.
module tb_nanorv32_ahb_testctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;

    nanorv32_ahb_testctrl_if bus0();
    nanorv32_ahb_testctrl_if bus2();

    assign bus0.hsel   = hsel & ~sel;
    assign bus2.hsel   = hsel & sel;
    assign bus0.haddr  = haddr;
    assign bus2.haddr  = haddr;
    assign bus0.htrans = htrans;
    assign bus2.htrans = htrans;
    assign bus0.hwrite = hwrite;
    assign bus2.hwrite = hwrite;
    assign bus0.hsize  = hsize;
    assign bus2.hsize  = hsize;
    assign bus0.hwdata = hwdata;
    assign bus2.hwdata = hwdata;
    assign bus0.hready = bus0.hready_out;
    assign bus2.hready = bus2.hready_out;

    logic       done0, pass0, cv0, done2, pass2, cv2;
    logic [7:0] cd0, cd2;

    nanorv32_ahb_testctrl #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .test_done(done0), .test_pass(pass0),
        .char_valid(cv0), .char_data(cd0)
    );

    nanorv32_ahb_testctrl #(.WAIT_STATES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .test_done(done2), .test_pass(pass2),
        .char_valid(cv2), .char_data(cd2)
    );

    logic        o_hready, o_hresp, o_done, o_pass, o_cv;
    logic [31:0] o_hrdata;
    logic [7:0]  o_cd;
    assign o_hready = sel ? bus2.hready_out : bus0.hready_out;
    assign o_hresp  = sel ? bus2.hresp : bus0.hresp;
    assign o_hrdata = sel ? bus2.hrdata : bus0.hrdata;
    assign o_done   = sel ? done2 : done0;
    assign o_pass   = sel ? pass2 : pass0;
    assign o_cv     = sel ? cv2 : cv0;
    assign o_cd     = sel ? cd2 : cd0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int cq_cyc[$];
    logic [7:0] cq_dat[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cv0) begin
            cq_cyc.push_back(cyc);
            cq_dat.push_back(cd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits,
                        output logic err);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = wr;
        haddr = addr; hsize = sz;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0;
        while (!o_hready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 20) check("timeout", 32'd1, 32'd0);
        rd = o_hrdata;
        err = o_hresp;
        @(posedge clk); #1;
    endtask

    task automatic xfer2(input logic wr,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] a2, input logic [31:0] d2,
                         output logic [31:0] r1, output logic [31:0] r2,
                         output int w1, output int w2);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = wr;
        hsize = 3'b010; haddr = a1;
        @(posedge clk); #1;
        haddr = a2; hwdata = d1; w1 = 0;
        while (!o_hready && w1 < 20) begin
            @(posedge clk); #1;
            w1++;
        end
        r1 = o_hrdata;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = d2; w2 = 0;
        while (!o_hready && w2 < 20) begin
            @(posedge clk); #1;
            w2++;
        end
        if (w1 >= 20 || w2 >= 20) check("timeout2", 32'd1, 32'd0);
        r2 = o_hrdata;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        hsel = 1'b0; htrans = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] rd, r1, r2;
    int w, w1, w2;
    logic err;

    initial begin
        do_reset();
        #1;
        check("rst_hready", o_hready, 1);
        check("rst_hresp", o_hresp, 0);
        check("rst_hrdata", o_hrdata, 0);
        check("rst_done", o_done, 0);
        check("rst_pass", o_pass, 0);
        check("rst_cv", o_cv, 0);
        check("rst_cd", o_cd, 0);

        xfer(1, 32'h08, 3'b010, 32'h12345678, rd, w, err);
        check("scr_wr_wait", w, 0);
        check("scr_wr_resp", err, 0);
        xfer(0, 32'h08, 3'b010, 32'h0, rd, w, err);
        check("scr_rd", rd, 32'h12345678);
        check("scr_rd_wait", w, 0);
        check("scr_rd_resp", err, 0);

        xfer(1, 32'h08, 3'b000, 32'hFFFFFFFF, rd, w, err);
        check("byte_err_wait", w, 1);
        check("byte_err_resp", err, 1);
        xfer(0, 32'h08, 3'b010, 32'h0, rd, w, err);
        check("scr_unchanged", rd, 32'h12345678);

        xfer(0, 32'h14, 3'b010, 32'h0, rd, w, err);
        check("unmap_wait", w, 1);
        check("unmap_resp", err, 1);
        check("unmap_rdata", rd, 0);

        xfer(1, 32'h04, 3'b010, 32'h0, rd, w, err);
        check("cnt_wr_resp", err, 0);
        check("cnt_wr_wait", w, 0);

        cq_cyc.delete();
        cq_dat.delete();
        xfer2(1, 32'h0C, 32'h41, 32'h0C, 32'h0A, r1, r2, w1, w2);
        repeat (3) @(posedge clk);
        #1;
        check("char_n", cq_cyc.size(), 2);
        if (cq_cyc.size() == 2) begin
            check("char_d0", cq_dat[0], 8'h41);
            check("char_d1", cq_dat[1], 8'h0A);
            check("char_adj", cq_cyc[1] - cq_cyc[0], 1);
        end
        xfer(0, 32'h0C, 3'b010, 32'h0, rd, w, err);
        check("char_rd", rd, 0);

        xfer(1, 32'h00, 3'b010, 32'hCAFFE000, rd, w, err);
        xfer(1, 32'h00, 3'b010, 32'hDEAD0000, rd, w, err);
        check("res_done", o_done, 1);
        check("res_pass", o_pass, 1);
        xfer(0, 32'h00, 3'b010, 32'h0, rd, w, err);
        check("res_rd", rd, 32'hCAFFE000);

        sel = 1'b1;
        xfer2(0, 32'h04, 32'h0, 32'h04, 32'h0, r1, r2, w1, w2);
        check("cc_w1", w1, 2);
        check("cc_w2", w2, 2);
        check("cc_delta", r2 - r1, 3);

        xfer(1, 32'h08, 3'b010, 32'hAAAA5555, rd, w, err);
        check("ws_wr_wait", w, 2);
        xfer(0, 32'h08, 3'b010, 32'h0, rd, w, err);
        check("ws_scr_rd", rd, 32'hAAAA5555);

        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        haddr = 32'h08; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF0000;
        check("mid_in_wait", o_hready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_hready", o_hready, 1);
        check("mid_hresp", o_hresp, 0);
        check("mid_hrdata", o_hrdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 32'h08, 3'b010, 32'h0, rd, w, err);
        check("mid_scr", rd, 0);
        check("mid_rd_wait", w, 2);

        sel = 1'b0;
        check("fresh_done", o_done, 0);
        xfer(1, 32'h00, 3'b010, 32'h00000001, rd, w, err);
        check("bad_done", o_done, 1);
        check("bad_pass", o_pass, 0);
        xfer(0, 32'h00, 3'b010, 32'h0, rd, w, err);
        check("bad_rd", rd, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nanorv32_ahb_testctrl.md
Name: nanorv32_ahb_testctrl

Overview:
- AHB-Lite responder (slave) for the nanorv32 AHB initiator. Firmware uses it to report test results and emit console characters; it also provides a cycle counter.
- Testbenches and simulation top-levels observe test_done / test_pass / char_valid instead of probing CPU internals.
- Register file of four 32-bit words with configurable wait states and an AHB ERROR response for illegal accesses.

Parameters:
- WAIT_STATES, 0, number of wait cycles (hready_out low) inserted in every OKAY data phase; legal range 0..3.
- PASS_CODE, 32'hCAFFE000, RESULT value meaning pass.
- FAIL_CODE, 32'hDEAD0000, RESULT value meaning fail.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- hsel  input  1  slave select
- haddr  input  32  byte address; only haddr[4:0] decoded
- htrans  input  2  AHB transfer type
- hwrite  input  1  1 = write
- hsize  input  3  transfer size
- hwdata  input  32  write data, valid in the data phase
- hready  input  1  bus-level HREADY
- hrdata  output  32  read data
- hready_out  output  1  slave HREADYOUT
- hresp  output  1  0 = OKAY, 1 = ERROR
- test_done  output  1  RESULT has been written
- test_pass  output  1  RESULT write equalled PASS_CODE
- char_valid  output  1  one-cycle strobe for a CHAR_OUT write
- char_data  output  8  character byte, valid with char_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. In reset, all state clears: hready_out=1, hresp=0, hrdata=0, test_done=0, test_pass=0, char_valid=0, char_data=0, cycle counter=0, SCRATCH=0, RESULT=0, FSM=IDLE.
- Register map (word offsets):
  - 0x00 RESULT: RW, first write wins.
  - 0x04 CYCLE_CNT: RO. Writes are ignored with an OKAY response.
  - 0x08 SCRATCH: RW.
  - 0x0C CHAR_OUT: WO; reads return 0.
  - Offsets 0x10..0x1F are unmapped.
- Address phase is accepted when hsel & htrans[1] & hready. On acceptance, capture haddr[4:2], hwrite, and a legal flag.
  - legal = (hsize==3'b010) & (haddr[1:0]==0) & (haddr[4]==0).
- IDLE and BUSY transfers, or hsel=0: no data phase, zero-wait OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, legal accepted, WAIT_STATES=0: stay IDLE; the data phase completes in the next cycle with hready_out=1.
  - IDLE, legal accepted, WAIT_STATES>0: go to WAIT; hready_out=0 for WAIT_STATES cycles; wait counter loads WAIT_STATES-1 and decrements. At 0, hready_out=1 (completion cycle) and the FSM returns to IDLE, or accepts a new address phase.
  - Illegal accepted: ERR1 (hresp=1, hready_out=0), then ERR2 (hresp=1, hready_out=1), then IDLE. No register side effects.
- Writes commit on the clk edge ending the completion cycle, using hwdata sampled in that cycle.
- Reads: hrdata is driven combinationally from the captured offset during the completion cycle; it is 0 in all other cycles. CYCLE_CNT read returns the counter value in the completion cycle.
- Pipelining: a new address phase is accepted in the same cycle the previous data phase completes. Back-to-back transfers at WAIT_STATES=0 sustain one transfer per cycle.
- RESULT register:
  - First write stores the value and sets test_done=1.
  - test_pass=(value==PASS_CODE) on that write.
  - Any value other than PASS_CODE gives test_pass=0; FAIL_CODE and unknown values are distinguished only by reading RESULT.
  - Later writes are ignored; the flags are sticky until reset.
- CYCLE_CNT: increments by 1 every clk from reset; 32-bit; wraps from FFFFFFFF to 0.
- CHAR_OUT write: char_data<=hwdata[7:0] and char_valid=1 for exactly one cycle after the commit edge. Consecutive writes produce consecutive strobes.
- Reset mid-transfer: any pending data phase or error sequence is discarded, with no register update.

Test Plan:
- WAIT_STATES=0: write SCRATCH=32'h12345678, then read back -> hrdata=32'h12345678 in the completion cycle; hready_out stays 1 and hresp=0 throughout.
- WAIT_STATES=2: read CYCLE_CNT twice back-to-back -> hready_out low 2 cycles per transfer; second value = first + 3.
- Write RESULT=32'hCAFFE000, then RESULT=32'hDEAD0000 -> test_done=1, test_pass=1; RESULT read = 32'hCAFFE000.
- Fresh reset, write RESULT=32'h00000001 -> test_done=1, test_pass=0.
- Illegal accesses:
  - Byte write (hsize=0) to 0x08 -> ERR1/ERR2 pattern (hresp=1; hready_out 0 then 1); SCRATCH unchanged.
  - Access to offset 0x14 -> same error pattern.
- Write CHAR_OUT 32'h00000041 then 32'h0000000A, back-to-back -> char_valid high 2 consecutive cycles; char_data 8'h41 then 8'h0A.
- rst_n low during WAIT state of a SCRATCH write -> outputs at reset values immediately; SCRATCH reads 0 after reset.
